svt_barrier_ctrl: RTL and testbench

Synthesizable objection barrier and end-of-test watchdog: the hardware side of the testbench's objection/timeout handshake. Up to N_REQ in-design agents raise and drop objections via single-cycle pulses. After a `start` pulse from the harness, the block waits until the objection count has been zero for DRAIN_CYCLES consecutive cycles, or until TIMEOUT_CYCLES have elapsed. It then presents a held pass/timeout result until the harness acknowledges it.

---
 rtl/svt_barrier_ctrl.sv | 161 ++++++++++++++++
 tb/tb_svt_barrier_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svt_barrier_ctrl.sv
// Objection barrier and end-of-test watchdog: counts raise/drop pulses and, after start,
// waits for a zero-objection drain window or a timeout, then holds the result until acknowledged.
module svt_barrier_ctrl #(
    parameter int N_REQ          = 4,
    parameter int CNT_W          = 8,
    parameter int TMR_W          = 32,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] raise,
    input  logic [N_REQ-1:0] drop,
    input  logic             start,
    input  logic             result_ack,
    output logic             busy,
    output logic             result_valid,
    output logic             timed_out,
    output logic [CNT_W-1:0] obj_count,
    output logic [TMR_W-1:0] elapsed,
    output logic             err_underflow,
    output logic             err_overflow
);

    localparam int PC_W  = $clog2(N_REQ + 1);
    localparam int SUM_W = CNT_W + PC_W + 2;
    localparam int DC_W  = $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DC_W-1:0]  DRAIN_LAST = DC_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [1:0]              state_r;
    logic [1:0]              state_next_s;
    logic [DC_W-1:0]         drain_cnt_r;
    logic [DC_W-1:0]         drain_next_s;
    logic [TMR_W-1:0]        elapsed_next_s;
    logic                    timed_next_s;
    logic signed [SUM_W-1:0] cnt_sum_s;
    logic [CNT_W-1:0]        cnt_next_s;
    logic                    ovf_s;
    logic                    unf_s;
    logic                    start_acc_s;
    logic                    to_hit_s;

    function automatic logic [PC_W-1:0] popcount(input logic [N_REQ-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Saturating objection counter; the sum is wide enough that sign and overflow are exact.
    always_comb begin
        cnt_sum_s = $signed({{(SUM_W-CNT_W){1'b0}}, obj_count})
                  + $signed({{(SUM_W-PC_W){1'b0}}, popcount(raise)})
                  - $signed({{(SUM_W-PC_W){1'b0}}, popcount(drop)});
        unf_s      = cnt_sum_s[SUM_W-1];
        ovf_s      = 1'b0;
        cnt_next_s = cnt_sum_s[CNT_W-1:0];
        if (unf_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (|cnt_sum_s[SUM_W-2:CNT_W]) begin
            ovf_s      = 1'b1;
            cnt_next_s = CNT_MAX;
        end else begin
            ovf_s      = 1'b0;
        end
    end

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign to_hit_s    = (TIMEOUT_CYCLES != 0) && (elapsed == TO_LAST);

    // Barrier FSM next-state; timeout is checked before the drain window.
    always_comb begin
        state_next_s   = state_r;
        drain_next_s   = drain_cnt_r;
        elapsed_next_s = elapsed;
        timed_next_s   = timed_out;
        case (state_r)
            ST_IDLE: begin
                elapsed_next_s = {TMR_W{1'b0}};
                timed_next_s   = 1'b0;
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                elapsed_next_s = elapsed + TMR_W'(1);
                if (to_hit_s) begin
                    state_next_s = ST_DONE;
                    timed_next_s = 1'b1;
                end else if (obj_count == {CNT_W{1'b0}}) begin
                    state_next_s = ST_DRAIN;
                    drain_next_s = DC_W'(1);
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                elapsed_next_s = elapsed + TMR_W'(1);
                if (to_hit_s) begin
                    state_next_s = ST_DONE;
                    timed_next_s = 1'b1;
                end else if (obj_count != {CNT_W{1'b0}}) begin
                    state_next_s = ST_RUN;
                end else if (drain_cnt_r == DRAIN_LAST) begin
                    state_next_s = ST_DONE;
                    timed_next_s = 1'b0;
                end else begin
                    drain_next_s = drain_cnt_r + DC_W'(1);
                end
            end
            ST_DONE: begin
                if (result_ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, sticky error flags and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            drain_cnt_r   <= {DC_W{1'b0}};
            elapsed       <= {TMR_W{1'b0}};
            timed_out     <= 1'b0;
            obj_count     <= {CNT_W{1'b0}};
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            drain_cnt_r   <= drain_next_s;
            elapsed       <= elapsed_next_s;
            timed_out     <= timed_next_s;
            obj_count     <= cnt_next_s;
            err_underflow <= (err_underflow & ~start_acc_s) | unf_s;
            err_overflow  <= (err_overflow & ~start_acc_s) | ovf_s;
            busy          <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
            result_valid  <= (state_next_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_svt_barrier_ctrl.sv
// Scoreboard bench for svt_barrier_ctrl: expected results are queued when a test
// creates a completion condition and compared by a monitor when result_valid rises.
module tb_svt_barrier_ctrl;

    localparam int N_REQ = 4;
    localparam int CNT_W = 2;
    localparam int TMR_W = 32;
    localparam int DRAIN = 4;
    localparam int TMO   = 20;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N_REQ-1:0] raise = '0;
    logic [N_REQ-1:0] drop  = '0;
    logic             start = 1'b0;
    logic             result_ack = 1'b0;
    logic             busy;
    logic             result_valid;
    logic             timed_out;
    logic [CNT_W-1:0] obj_count;
    logic [TMR_W-1:0] elapsed;
    logic             err_underflow;
    logic             err_overflow;

    typedef struct {
        bit to;
        int cyc;
        int el;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rv_prev = 1'b0;

    svt_barrier_ctrl #(
        .N_REQ(N_REQ), .CNT_W(CNT_W), .TMR_W(TMR_W),
        .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .raise(raise), .drop(drop),
        .start(start), .result_ack(result_ack), .busy(busy),
        .result_valid(result_valid), .timed_out(timed_out),
        .obj_count(obj_count), .elapsed(elapsed),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    always #5 clock = ~clock;

    // Result monitor: pops the scoreboard on each rising result_valid.
    always @(negedge clock) begin
        if (result_valid && !rv_prev) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected result at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL sb_cycle got %0d exp %0d", cyc, mon_e.cyc);
                end
                checks++;
                if (timed_out !== mon_e.to) begin
                    errors++;
                    $display("FAIL sb_timed_out got %0b exp %0b", timed_out, mon_e.to);
                end
                checks++;
                if (elapsed !== TMR_W'(mon_e.el)) begin
                    errors++;
                    $display("FAIL sb_elapsed got %0d exp %0d", elapsed, mon_e.el);
                end
            end
        end
        rv_prev = result_valid;
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int n;
        n = 0;
        while (!result_valid && n < budget) begin
            tick();
            n++;
        end
        ok = result_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raise = 4'b1111;
        tick();
        tick();
        checks++;
        if ({busy, result_valid, timed_out, err_underflow, err_overflow} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {busy, result_valid, timed_out, err_underflow, err_overflow});
        end
        checks++;
        if (obj_count !== 2'd0 || elapsed !== 32'd0) begin
            errors++;
            $display("FAIL reset_values got obj %0d el %0d exp 0 0", obj_count, elapsed);
        end
        reset = 1'b0;
        raise = 4'b0000;
        tick();
        checks++;
        if (obj_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_raise_discard got %0d exp 0", obj_count);
        end
    endtask

    task automatic test_clean_drain();
        int r;
        int z;
        bit ok;
        raise = 4'b0001;
        tick();
        raise = 4'b0000;
        checks++;
        if (obj_count !== 2'd1) begin
            errors++;
            $display("FAIL clean_raise got %0d exp 1", obj_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        r = cyc;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_busy got %0b exp 1", busy);
        end
        repeat (6) tick();
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL clean_hold got busy %0b rv %0b exp 1 0", busy, result_valid);
        end
        drop = 4'b0001;
        tick();
        drop = 4'b0000;
        z = cyc;
        sb.push_back('{1'b0, z + DRAIN + 1, z + DRAIN + 1 - r});
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL clean_wait got no result exp result_valid");
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || busy !== 1'b0 || elapsed !== TMR_W'(z + DRAIN + 1 - r)) begin
            errors++;
            $display("FAIL done_start_ignored got rv %0b busy %0b el %0d exp 1 0 %0d",
                     result_valid, busy, elapsed, z + DRAIN + 1 - r);
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL clean_ack got %0b exp 0", result_valid);
        end
    endtask

    task automatic test_drain_interrupt();
        int r;
        int z2;
        bit ok;
        raise = 4'b0001;
        tick();
        raise = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        r = cyc;
        tick();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_ack_ignored got busy %0b rv %0b exp 1 0", busy, result_valid);
        end
        drop = 4'b0001;
        tick();
        drop = 4'b0000;
        tick();
        tick();
        raise = 4'b0100;
        tick();
        raise = 4'b0000;
        checks++;
        if (obj_count !== 2'd1) begin
            errors++;
            $display("FAIL interrupt_raise got %0d exp 1", obj_count);
        end
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL interrupt_busy got busy %0b rv %0b exp 1 0", busy, result_valid);
        end
        drop = 4'b0100;
        tick();
        drop = 4'b0000;
        z2 = cyc;
        sb.push_back('{1'b0, z2 + DRAIN + 1, z2 + DRAIN + 1 - r});
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL interrupt_wait got no result exp result_valid");
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int r;
        bit ok;
        raise = 4'b0010;
        tick();
        raise = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        r = cyc;
        sb.push_back('{1'b1, r + TMO, TMO});
        wait_valid(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_wait got no result exp result_valid");
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ack got %0b exp 0", result_valid);
        end
        // Restart in the IDLE cycle right after DONE; timeout lands on the last drain cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        r = cyc;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy got %0b exp 1", busy);
        end
        repeat (14) tick();
        drop = 4'b0010;
        tick();
        drop = 4'b0000;
        checks++;
        if (obj_count !== 2'd0) begin
            errors++;
            $display("FAIL coincide_drop got %0d exp 0", obj_count);
        end
        sb.push_back('{1'b1, r + TMO, TMO});
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL coincide_wait got no result exp result_valid");
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic test_count_arith();
        int r;
        int z;
        bit ok;
        raise = 4'b1111;
        drop  = 4'b0001;
        tick();
        checks++;
        if (obj_count !== 2'd3 || err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL arith_plus3 got %0d ovf %0b exp 3 0", obj_count, err_overflow);
        end
        raise = 4'b0001;
        drop  = 4'b0000;
        tick();
        checks++;
        if (obj_count !== 2'd3 || err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL arith_saturate got %0d ovf %0b exp 3 1", obj_count, err_overflow);
        end
        raise = 4'b0000;
        drop  = 4'b1111;
        tick();
        checks++;
        if (obj_count !== 2'd0 || err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL arith_clamp got %0d unf %0b exp 0 1", obj_count, err_underflow);
        end
        raise = 4'b0010;
        drop  = 4'b0010;
        tick();
        raise = 4'b0001;
        drop  = 4'b0000;
        checks++;
        if (obj_count !== 2'd0) begin
            errors++;
            $display("FAIL arith_cancel got %0d exp 0", obj_count);
        end
        tick();
        raise = 4'b0000;
        checks++;
        if (obj_count !== 2'd1 || err_overflow !== 1'b1 || err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL arith_sticky got %0d ovf %0b unf %0b exp 1 1 1",
                     obj_count, err_overflow, err_underflow);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        r = cyc;
        checks++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL arith_flag_clear got ovf %0b unf %0b exp 0 0", err_overflow, err_underflow);
        end
        drop = 4'b1000;
        tick();
        drop = 4'b0000;
        z = cyc;
        sb.push_back('{1'b0, z + DRAIN + 1, z + DRAIN + 1 - r});
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL arith_wait got no result exp result_valid");
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        raise = 4'b0001;
        tick();
        raise = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        drop = 4'b0011;
        tick();
        drop = 4'b0000;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || err_underflow !== 1'b1 || elapsed === 32'd0) begin
            errors++;
            $display("FAIL mid_pre got busy %0b unf %0b el %0d exp 1 1 nonzero",
                     busy, err_underflow, elapsed);
        end
        reset = 1'b1;
        raise = 4'b1111;
        tick();
        reset = 1'b0;
        raise = 4'b0000;
        checks++;
        if ({busy, result_valid, timed_out, err_underflow, err_overflow} !== 5'b00000 ||
            obj_count !== 2'd0 || elapsed !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got flags %b obj %0d el %0d exp 00000 0 0",
                     {busy, result_valid, timed_out, err_underflow, err_overflow},
                     obj_count, elapsed);
        end
        repeat (10) tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_result got rv %0b busy %0b exp 0 0", result_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_clean_drain();
        test_drain_interrupt();
        test_back_to_back();
        test_count_arith();
        test_reset_mid();
        tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
